program_loader: RTL

Boot-time loader that sits directly downstream of the CPU state controller and consumes its `receive_program_data_size` and `receive_program_data` phase enables. While a phase is enabled, it accepts bytes from the UART receiver, assembles a 32-bit little-endian byte count, then packs program bytes into 32-bit words and writes them to instruction memory. It reports completion to the controller through `receive_program_data_size_finished` and `receive_program_data_finished`.

---
 rtl/loader_pkg.sv | 16 +
 rtl/program_loader_word_packer.sv | 41 ++++
 rtl/program_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Imported by the loader FSM and its word packer.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SIZE,
    SIZE_DONE,
    DATA,
    DATA_DONE
  } loader_state_t;

  localparam int SIZE_BYTES = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/program_loader_word_packer.sv
// Packs received bytes little-endian into 32-bit words.
// Flags a finished word on lane 3 or on the last program byte.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        push,
  input  logic        last,
  input  logic [7:0]  data,
  output logic        done,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [31:0] acc;

  // Lane 0 starts a fresh word, so unfilled upper lanes read as zero
  always_comb begin
    word = (lane == 2'd0) ? 32'd0 : acc;
    word[{lane, 3'b000} +: 8] = data;
  end

  assign done = push &&
    ((lane == 2'(WORD_BYTES - 1)) || last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane <= 2'd0;
      acc  <= 32'd0;
    end else if (clear) begin
      lane <= 2'd0;
      acc  <= 32'd0;
    end else if (push) begin
      acc  <= word;
      lane <= done ? 2'd0 : lane + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: latches a 32-bit byte count from the UART, then
// streams program bytes into instruction memory as 32-bit words.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       receive_program_data_size,
  input  logic                       receive_program_data,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       receive_program_data_size_finished,
  output logic                       receive_program_data_finished,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [31:0]                program_size
);

  loader_state_t state, state_next;

  logic [31:0] cnt;
  logic        cnt_clr;
  logic        size_take;
  logic        pk_clr;
  logic        pk_push;
  logic        pk_done;
  logic [31:0] pk_word;
  logic        last;
  logic        fits;

  assign last = (cnt == program_size - 32'd1);
  // Word index beyond memory depth: keep counting, drop the write
  assign fits = ((cnt >> (IMEM_ADDR_WIDTH + 2)) == 32'd0);

  assign receive_program_data_size_finished = (state == SIZE_DONE);
  assign receive_program_data_finished = (state == DATA_DONE);

  word_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pk_clr),
    .push    (pk_push),
    .last    (last),
    .data    (rx_data),
    .done    (pk_done),
    .word    (pk_word)
  );

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    size_take  = 1'b0;
    pk_clr     = 1'b0;
    pk_push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (receive_program_data_size) begin
          state_next = SIZE;
          cnt_clr    = 1'b1;
        end else if (receive_program_data) begin
          state_next = DATA;
          cnt_clr    = 1'b1;
          pk_clr     = 1'b1;
        end
      end
      SIZE: begin
        if (!receive_program_data_size) begin
          state_next = IDLE;
        end else if (rx_valid) begin
          size_take = 1'b1;
          if (cnt == 32'(SIZE_BYTES - 1))
            state_next = SIZE_DONE;
        end
      end
      SIZE_DONE: begin
        if (!receive_program_data_size)
          state_next = IDLE;
      end
      DATA: begin
        if (!receive_program_data) begin
          state_next = IDLE;
        end else if (program_size == 32'd0) begin
          state_next = DATA_DONE;
        end else if (rx_valid) begin
          pk_push = 1'b1;
          if (last)
            state_next = DATA_DONE;
        end
      end
      DATA_DONE: begin
        if (!receive_program_data)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 32'd0;
      program_size <= 32'd0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
    end else begin
      state   <= state_next;
      imem_we <= 1'b0;
      if (cnt_clr)
        cnt <= 32'd0;
      else if (size_take || pk_push)
        cnt <= cnt + 32'd1;
      if (size_take)
        program_size[{cnt[1:0], 3'b000} +: 8] <= rx_data;
      if (pk_done && fits) begin
        imem_we    <= 1'b1;
        imem_addr  <= cnt[IMEM_ADDR_WIDTH+1:2];
        imem_wdata <= pk_word;
      end
    end
  end

endmodule
